// File: rtl/eclair_mac_requant_if.sv
// Stream bundle between the multiplier stage, the MAC/requant block and the
// activation stage. "slave" is the MAC/requant block itself; "master" is the
// surrounding environment that feeds products and drains results.
interface eclair_mac_requant_if #(
  parameter int PROD_W = 26,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16
);
  logic signed [PROD_W-1:0] prod_tdata;
  logic                     prod_tvalid;
  logic                     prod_tlast;
  logic                     prod_tready;
  logic signed [ACC_W-1:0]  bias;
  logic signed [OUT_W-1:0]  res_tdata;
  logic                     res_tvalid;
  logic                     res_tready;
  logic                     res_sat;
  logic                     len_err;

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, bias, res_tready,
    output prod_tready, res_tdata, res_tvalid, res_sat, len_err
  );

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, bias, res_tready,
    input  prod_tready, res_tdata, res_tvalid, res_sat, len_err
  );
endinterface

// File: rtl/eclair_mac_requant.sv
// eclair_mac_requant: accumulates N_TERMS signed products plus a bias into a
// dot product, then rounds (half toward +inf), arithmetic-shifts by SHIFT and
// saturates to OUT_W bits. One result per vector on a valid/ready output.
// Optional build macro ECLAIR_RELU_EN: clamp negative results to zero after
// saturation (res_sat still reports a clip).
module eclair_mac_requant #(
  parameter int PROD_W  = 26,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 10,
  parameter int N_TERMS = 4
) (
  input logic                ap_clk,
  input logic                ap_rst_n,
  eclair_mac_requant_if.slave bus
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);
  // Rounding constant 2^(SHIFT-1), held in the widened requant domain.
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [OUT_W-1:0] res_tdata_q;
  logic                    res_tvalid_q;
  logic                    res_sat_q;
  logic                    len_err_q;

  logic                    accept;
  logic                    at_limit;
  logic                    close_vec;
  logic                    bad_len;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   shifted;
  logic [ACC_W-OUT_W+1:0]  upper;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic signed [OUT_W-1:0] res_d;
  logic                    sat_d;

  assign bus.prod_tready = (state_q != S_OUT);
  assign bus.res_tdata   = res_tdata_q;
  assign bus.res_tvalid  = res_tvalid_q;
  assign bus.res_sat     = res_sat_q;
  assign bus.len_err     = len_err_q;

  // Next accumulator value, vector-close decision and the requantized result
  // of the sum that would be formed by the current beat.
  always_comb begin
    accept    = bus.prod_tvalid && (state_q != S_OUT);
    at_limit  = (cnt_q == LAST_IDX);
    close_vec = accept && (bus.prod_tlast || at_limit);
    // Length is wrong when tlast disagrees with the beat position.
    bad_len   = (bus.prod_tlast != at_limit);
    prod_ext  = {{(ACC_W - PROD_W){bus.prod_tdata[PROD_W-1]}}, bus.prod_tdata};
    // Bias only enters on the first beat of a vector.
    acc_base  = (state_q == S_IDLE) ? bus.bias : acc_q;
    acc_d     = acc_base + prod_ext;
    rounded   = {acc_d[ACC_W-1], acc_d} + HALF;
    shifted   = rounded >>> SHIFT;
    // In range iff every bit from the OUT_W sign bit upward matches.
    upper     = shifted[ACC_W:OUT_W-1];
    pos_ovf   = !shifted[ACC_W] && (|upper);
    neg_ovf   = shifted[ACC_W] && !(&upper);
    sat_d     = pos_ovf || neg_ovf;
    if (pos_ovf) begin
      res_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (neg_ovf) begin
      res_d = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res_d = shifted[OUT_W-1:0];
    end
`ifdef ECLAIR_RELU_EN
    if (res_d[OUT_W-1]) begin
      res_d = '0;
    end
`endif
  end

  // Control FSM: accumulate beats, capture result on close, release on handshake.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      res_tdata_q  <= '0;
      res_tvalid_q <= 1'b0;
      res_sat_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (close_vec) begin
              state_q      <= S_OUT;
              res_tvalid_q <= 1'b1;
              res_tdata_q  <= res_d;
              res_sat_q    <= sat_d;
              if (bad_len) begin
                len_err_q <= 1'b1;
              end
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_OUT: begin
          if (bus.res_tready) begin
            res_tvalid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eclair_mac_requant.sv
// Self-checking bench for eclair_mac_requant: directed vectors followed by
// randomized vectors compared against an arithmetic reference model.
module tb_eclair_mac_requant;
  localparam int PROD_W  = 26;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 10;
  localparam int N_TERMS = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  eclair_mac_requant_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  eclair_mac_requant #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .N_TERMS(N_TERMS)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  int     tests = 0;
  int     fails = 0;
  bit     exp_len_err = 1'b0;
  longint pq[$];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: floor((sum + 2^(SHIFT-1)) / 2^SHIFT), clipped to OUT_W signed range.
  function automatic void model(input longint b, output longint r, output longint s);
    longint sum, q, lim_hi, lim_lo;
    sum = b;
    foreach (pq[i]) sum += pq[i];
    q = sum + (longint'(1) << (SHIFT - 1));
    r = q / (longint'(1) << SHIFT);
    if (q < 0 && (q % (longint'(1) << SHIFT)) != 0) r = r - 1;
    lim_hi = (longint'(1) << (OUT_W - 1)) - 1;
    lim_lo = -(longint'(1) << (OUT_W - 1));
    s = 0;
    if (r > lim_hi) begin r = lim_hi; s = 1; end
    if (r < lim_lo) begin r = lim_lo; s = 1; end
`ifdef ECLAIR_RELU_EN
    if (r < 0) r = 0;
`endif
  endfunction

  function automatic longint rand_prod(input int bits);
    logic signed [PROD_W-1:0] t;
    int unsigned u;
    u = $urandom;
    t = PROD_W'(u);
    if (bits < PROD_W) t = t >>> (PROD_W - bits);
    return longint'(t);
  endfunction

  task automatic set4(input longint a, input longint b, input longint c, input longint d);
    pq.delete();
    pq.push_back(a); pq.push_back(b); pq.push_back(c); pq.push_back(d);
  endtask

  // Send pq as one vector (tlast on beat tlast_at, -1 = none), check the
  // result, hold backpressure for `hold` cycles, then complete the handshake.
  task automatic send_vector(input string tag, input longint b, input int tlast_at, input int hold);
    longint exp_r, exp_s, held;
    int w;
    for (int i = 0; i < pq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.prod_tvalid = 1'b0;
        bus.prod_tdata  = PROD_W'($urandom);
        tick();
      end
      bus.bias        = (i == 0) ? ACC_W'(b) : ACC_W'($urandom);
      bus.prod_tdata  = PROD_W'(pq[i]);
      bus.prod_tlast  = (i == tlast_at);
      bus.prod_tvalid = 1'b1;
      w = 0;
      while (!bus.prod_tready && w < 50) begin tick(); w++; end
      if (w >= 50) check({tag, " tready_timeout"}, 0, 1);
      tick();
    end
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    model(b, exp_r, exp_s);
    if (tlast_at != N_TERMS - 1) exp_len_err = 1'b1;
    check({tag, " res_tvalid"}, 64'(bus.res_tvalid), 1);
    check({tag, " res_tdata"}, bus.res_tdata, exp_r);
    check({tag, " res_sat"}, 64'(bus.res_sat), exp_s);
    check({tag, " len_err"}, 64'(bus.len_err), 64'(exp_len_err));
    held = bus.res_tdata;
    for (int h = 0; h < hold; h++) begin
      bus.prod_tvalid = 1'b1;
      bus.prod_tlast  = 1'b1;
      bus.prod_tdata  = PROD_W'($urandom);
      tick();
      check({tag, " hold_data"}, bus.res_tdata, held);
      check({tag, " hold_tready"}, 64'(bus.prod_tready), 0);
    end
    bus.res_tready = 1'b1;
    tick();
    bus.res_tready  = 1'b0;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    check({tag, " after_hs_tvalid"}, 64'(bus.res_tvalid), 0);
    $display("[TB] %s: bias=%0d beats=%0d -> expected %0d sat=%0d", tag, b, pq.size(), exp_r, exp_s);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tl, bits;
    longint b;
    bus.prod_tdata  = '0;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    bus.bias        = '0;
    bus.res_tready  = 1'b0;
    ap_rst_n = 1'b0;
    tick(); tick();
    check("reset res_tdata", bus.res_tdata, 0);
    check("reset res_tvalid", 64'(bus.res_tvalid), 0);
    check("reset res_sat", 64'(bus.res_sat), 0);
    check("reset len_err", 64'(bus.len_err), 0);
    check("reset prod_tready", 64'(bus.prod_tready), 1);
    ap_rst_n = 1'b1;
    tick();

    // Basic dot product and rounding corners
    set4(1024, 2048, -512, 512);   send_vector("t1_basic", 0, 3, 0);
    set4(512, 0, 0, 0);            send_vector("t2_rnd_512", 0, 3, 0);
    set4(511, 0, 0, 0);            send_vector("t2_rnd_511", 0, 3, 0);
    set4(-512, 0, 0, 0);           send_vector("t2_rnd_m512", 0, 3, 0);
    set4(-513, 0, 0, 0);           send_vector("t2_rnd_m513", 0, 3, 0);
    set4(0, 0, 0, 0);              send_vector("t2_bias1536", 1536, 3, 0);
    // Saturation at both rails
    set4(33554431, 33554431, 33554431, 33554431);     send_vector("t3_sat_pos", 0, 3, 0);
    set4(-33554432, -33554432, -33554432, -33554432); send_vector("t3_sat_neg", 0, 3, 0);
    // Backpressure with blocked products offered meanwhile
    set4(1024, 2048, -512, 512);   send_vector("t4_backpressure", 0, 3, 5);
    set4(4096, -1024, 0, 100);     send_vector("t4_after_bp", 77, 3, 0);
    // Short vector, then missing tlast
    pq.delete(); pq.push_back(1024); pq.push_back(1024);
    send_vector("t5_short", 0, 1, 0);
    set4(1024, 2048, -512, 512);   send_vector("t5_no_tlast", 0, -1, 0);
    set4(1024, 1024, 0, 0);        send_vector("t5_sticky", 0, 3, 0);

    // Reset in the middle of a vector
    bus.bias = ACC_W'(5000);
    bus.prod_tdata = PROD_W'(300000); bus.prod_tvalid = 1'b1; tick();
    bus.prod_tdata = PROD_W'(300000); tick();
    bus.prod_tvalid = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    exp_len_err = 1'b0;
    check("t6 rst res_tdata", bus.res_tdata, 0);
    check("t6 rst res_tvalid", 64'(bus.res_tvalid), 0);
    check("t6 rst res_sat", 64'(bus.res_sat), 0);
    check("t6 rst len_err", 64'(bus.len_err), 0);
    check("t6 rst prod_tready", 64'(bus.prod_tready), 1);
    tick();
    set4(1024, 2048, -512, 512);   send_vector("t6_after_rst", 0, 3, 0);
    set4(-3072, 0, 0, 0);          send_vector("t6_negative", 0, 3, 0);

    // Randomized vectors
    for (int v = 0; v < 30; v++) begin
      n = $urandom_range(2, N_TERMS);
      bits = ($urandom_range(0, 1) == 0) ? 18 : PROD_W;
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(rand_prod(bits));
      b = longint'($urandom_range(0, 1 << 23)) - (1 << 22);
      if (bits == PROD_W) b = b * 32;
      tl = n - 1;
      if (n == N_TERMS && $urandom_range(0, 3) == 0) tl = -1;
      send_vector($sformatf("rand%0d", v), b, tl, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
